// File: rtl/tmd_instr_fetch_unit_pkg.sv
// ============================================================================
// Module   : tmd_instr_fetch_unit_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tmd_instr_fetch_unit_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;
  // Redirects may stack several queue-loads of stale responses in memory.
  localparam int DISCARD_W   = 16;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     data;
    logic            filled;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/tmd_instr_fetch_unit_if.sv
// ============================================================================
// Module   : tmd_instr_fetch_unit_if
// Brief    : Memory request/response and decode handshake bundle of the IFU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tmd_instr_fetch_unit_if;
  import tmd_instr_fetch_unit_pkg::*;

  logic            mem_req_valid_o;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_req_ready_i;
  logic            mem_rsp_valid_i;
  logic [31:0]     mem_rsp_data_i;
  logic            instr_valid_o;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            instr_ready_i;

  modport master (
    output mem_req_valid_o, mem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, instr_ready_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i, instr_ready_i
  );

endinterface

`default_nettype wire

// File: rtl/tmd_fetch_queue.sv
// ============================================================================
// Module   : tmd_fetch_queue
// Brief    : In-order fetch queue: slot storage with alloc/fill/head pointers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmd_fetch_queue
  import tmd_instr_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  wire logic            clk_i,
  input  wire logic            arst_ni,
  input  wire logic            clear_i,
  input  wire logic            alloc_i,
  input  wire logic [XLEN-1:0] alloc_pc_i,
  input  wire logic            fill_i,
  input  wire logic [31:0]     fill_data_i,
  input  wire logic            pop_i,
  output logic                 full_o,
  output logic [PW-1:0]        outstanding_o,
  output logic                 head_valid_o,
  output logic [XLEN-1:0]      head_pc_o,
  output logic [31:0]          head_data_o
);

  fetch_entry_t  slot_q [DEPTH];
  logic [PW-1:0] alloc_q, fill_q, head_q;
  logic [PW-1:0] w_used;

  assign w_used        = alloc_q - head_q;
  assign full_o        = (w_used == PW'(DEPTH));
  assign outstanding_o = alloc_q - fill_q;
  assign head_valid_o  = slot_q[head_q[PW-2:0]].filled & (head_q != alloc_q);
  assign head_pc_o     = slot_q[head_q[PW-2:0]].pc;
  assign head_data_o   = slot_q[head_q[PW-2:0]].data;

  // Alloc, fill and pop always address distinct slots, so they may coexist.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else if (clear_i) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i].filled <= 1'b0;
    end else begin
      if (alloc_i) begin
        slot_q[alloc_q[PW-2:0]] <= '{pc: alloc_pc_i, data: 32'h0, filled: 1'b0};
        alloc_q <= alloc_q + 1'b1;
      end
      if (fill_i) begin
        slot_q[fill_q[PW-2:0]].data   <= fill_data_i;
        slot_q[fill_q[PW-2:0]].filled <= 1'b1;
        fill_q <= fill_q + 1'b1;
      end
      if (pop_i) begin
        slot_q[head_q[PW-2:0]].filled <= 1'b0;
        head_q <= head_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tmd_instr_fetch_unit.sv
// ============================================================================
// Module   : tmd_instr_fetch_unit
// Brief    : Fetch PC, memory request issue, redirect/discard handling.
//            Optional redirect counter enabled by TMD_IFU_FLUSH_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmd_instr_fetch_unit
  import tmd_instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int              QUEUE_DEPTH = 4
) (
  input  wire logic            clk_i,
  input  wire logic            arst_ni,
  input  wire logic            redirect_valid_i,
  input  wire logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0]      pc_o,
  output logic [31:0]          flush_count_o,
  tmd_instr_fetch_unit_if.master bus_if
);

  localparam int PW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0]      pc_q, pc_d;
  logic [DISCARD_W-1:0] discard_q, discard_d;
  logic                 req_en_q;
  logic                 w_full, w_req_valid, w_req_fire, w_discarding, w_fill, w_pop;
  logic                 w_instr_valid;
  logic [PW-1:0]        w_outstanding;
  logic [XLEN-1:0]      w_redirect_pc;

  assign w_redirect_pc = redirect_pc_i & ~XLEN'(INSTR_BYTES - 1);
  // req_en_q keeps the request port quiet until the first edge after reset.
  assign w_req_valid   = req_en_q & ~w_full & ~redirect_valid_i;
  assign w_req_fire    = w_req_valid & bus_if.mem_req_ready_i;
  assign w_discarding  = (discard_q != '0);
  assign w_fill        = bus_if.mem_rsp_valid_i & ~w_discarding & ~redirect_valid_i;
  assign w_pop         = w_instr_valid & bus_if.instr_ready_i;

  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid_i) begin
      pc_d      = w_redirect_pc;
      discard_d = discard_q + DISCARD_W'(w_outstanding)
                - DISCARD_W'(bus_if.mem_rsp_valid_i);
    end else begin
      if (w_req_fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
      if (bus_if.mem_rsp_valid_i && w_discarding) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
      req_en_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      req_en_q  <= 1'b1;
    end
  end

  tmd_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i         (clk_i),
    .arst_ni       (arst_ni),
    .clear_i       (redirect_valid_i),
    .alloc_i       (w_req_fire),
    .alloc_pc_i    (pc_q),
    .fill_i        (w_fill),
    .fill_data_i   (bus_if.mem_rsp_data_i),
    .pop_i         (w_pop),
    .full_o        (w_full),
    .outstanding_o (w_outstanding),
    .head_valid_o  (w_instr_valid),
    .head_pc_o     (bus_if.instr_pc_o),
    .head_data_o   (bus_if.instr_o)
  );

  assign pc_o                   = pc_q;
  assign bus_if.mem_req_valid_o = w_req_valid;
  assign bus_if.mem_req_addr_o  = pc_q;
  assign bus_if.instr_valid_o   = w_instr_valid;

`ifdef TMD_IFU_FLUSH_COUNT_EN
  logic [31:0] flush_count_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      flush_count_q <= '0;
    end else if (redirect_valid_i && (flush_count_q != 32'hFFFF_FFFF)) begin
      flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign flush_count_o = flush_count_q;
`else
  assign flush_count_o = 32'h0;
`endif

  a_rsp_expected: assert property (@(posedge clk_i) disable iff (!arst_ni)
    bus_if.mem_rsp_valid_i |-> (w_discarding || (w_outstanding != '0)));

endmodule

`default_nettype wire

// File: tb/tb_tmd_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_tmd_instr_fetch_unit
// Brief    : Directed self-checking bench for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmd_instr_fetch_unit;
  import tmd_instr_fetch_unit_pkg::*;

  localparam logic [63:0] C_RESET_PC = 64'h0000_0000_8000_0000;

  logic            clk_i;
  logic            arst_ni;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     flush_count_o;

  tmd_instr_fetch_unit_if bus_if ();

  tmd_instr_fetch_unit #(
    .RESET_PC    (C_RESET_PC),
    .QUEUE_DEPTH (4)
  ) u_dut (
    .clk_i            (clk_i),
    .arst_ni          (arst_ni),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_o             (pc_o),
    .flush_count_o    (flush_count_o),
    .bus_if           (bus_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] pend[$];
  bit          mem_auto = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // One clock; memory returns the oldest pending request one cycle later.
  task automatic step();
    logic        fire;
    logic [63:0] a;
    fire = bus_if.mem_req_valid_o & bus_if.mem_req_ready_i;
    a    = bus_if.mem_req_addr_o;
    @(posedge clk_i);
    if (fire) pend.push_back(a);
    #1;
    if (mem_auto && pend.size() > 0) begin
      bus_if.mem_rsp_valid_i = 1'b1;
      bus_if.mem_rsp_data_i  = data_of(pend.pop_front());
    end else begin
      bus_if.mem_rsp_valid_i = 1'b0;
    end
  endtask

  task automatic do_reset(input bit chk);
    arst_ni                = 1'b0;
    redirect_valid_i       = 1'b0;
    redirect_pc_i          = '0;
    bus_if.mem_req_ready_i = 1'b1;
    bus_if.mem_rsp_valid_i = 1'b0;
    bus_if.mem_rsp_data_i  = '0;
    bus_if.instr_ready_i   = 1'b1;
    mem_auto               = 1'b0;
    pend.delete();
    repeat (2) @(posedge clk_i);
    #1;
    if (chk) begin
      check("rst_pc",        pc_o, C_RESET_PC);
      check("rst_req_valid", bus_if.mem_req_valid_o, 0);
      check("rst_instr_vld", bus_if.instr_valid_o, 0);
      check("rst_instr",     bus_if.instr_o, 0);
      check("rst_instr_pc",  bus_if.instr_pc_o, 0);
      check("rst_flush_cnt", flush_count_o, 0);
    end
    arst_ni = 1'b1;
    step();
  endtask

  task automatic wait_instr(input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus_if.instr_valid_o) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_seen"}, found, 1);
  endtask

  initial begin
    int          fires;
    logic [63:0] fire_addr;

    // Streaming with one-cycle memory and an always-ready decoder.
    do_reset(1'b1);
    mem_auto = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stream_req_vld%0d", i), bus_if.mem_req_valid_o, 1);
      check($sformatf("stream_addr%0d", i), bus_if.mem_req_addr_o, C_RESET_PC + 64'(4 * i));
      if (i >= 2) begin
        check($sformatf("stream_ivld%0d", i), bus_if.instr_valid_o, 1);
        check($sformatf("stream_ipc%0d", i), bus_if.instr_pc_o, C_RESET_PC + 64'(4 * (i - 2)));
        check($sformatf("stream_idata%0d", i), bus_if.instr_o,
              {32'h0, data_of(C_RESET_PC + 64'(4 * (i - 2)))});
      end
      step();
    end

    // Memory stalled: request held stable.
    do_reset(1'b0);
    bus_if.mem_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_vld%0d", i), bus_if.mem_req_valid_o, 1);
      check($sformatf("stall_addr%0d", i), bus_if.mem_req_addr_o, C_RESET_PC);
      step();
    end

    // Decoder stalled: queue fills after four requests.
    do_reset(1'b0);
    bus_if.instr_ready_i = 1'b0;
    mem_auto = 1'b1;
    fires = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus_if.mem_req_valid_o && bus_if.mem_req_ready_i) fires++;
      step();
    end
    check("full_fires", fires, 4);
    check("full_req_vld", bus_if.mem_req_valid_o, 0);
    check("full_head_pc", bus_if.instr_pc_o, C_RESET_PC);
    bus_if.instr_ready_i = 1'b1;
    step();
    bus_if.instr_ready_i = 1'b0;
    check("pop_head_pc", bus_if.instr_pc_o, C_RESET_PC + 64'h4);
    fires = 0;
    fire_addr = '0;
    for (int i = 0; i < 6; i++) begin
      if (bus_if.mem_req_valid_o && bus_if.mem_req_ready_i) begin
        fires++;
        fire_addr = bus_if.mem_req_addr_o;
      end
      step();
    end
    check("pop_fires", fires, 1);
    check("pop_addr", fire_addr, C_RESET_PC + 64'h10);

    // Redirect with three requests outstanding.
    do_reset(1'b0);
    repeat (3) step();
    check("redir_pend", pend.size(), 3);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h8000_0100;
    #1;
    check("redir_req_blocked", bus_if.mem_req_valid_o, 0);
    step();
    redirect_valid_i = 1'b0;
    #1;
    check("redir_ivld", bus_if.instr_valid_o, 0);
    check("redir_addr", bus_if.mem_req_addr_o, 64'h8000_0100);
    mem_auto = 1'b1;
    wait_instr("redir");
    check("redir_first_pc", bus_if.instr_pc_o, 64'h8000_0100);
    check("redir_first_data", bus_if.instr_o, {32'h0, data_of(64'h8000_0100)});

    // Redirect coinciding with a response, misaligned target.
    do_reset(1'b0);
    repeat (2) step();
    redirect_valid_i       = 1'b1;
    redirect_pc_i          = 64'h8000_0203;
    bus_if.mem_rsp_valid_i = 1'b1;
    bus_if.mem_rsp_data_i  = data_of(pend.pop_front());
    step();
    redirect_valid_i = 1'b0;
    #1;
    check("coinc_addr_aligned", bus_if.mem_req_addr_o, 64'h8000_0200);
    mem_auto = 1'b1;
    wait_instr("coinc");
    check("coinc_first_pc", bus_if.instr_pc_o, 64'h8000_0200);

    // Back-to-back redirects: last wins, discard accumulates.
    do_reset(1'b0);
    repeat (2) step();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 64'h8000_0300;
    step();
    redirect_pc_i    = 64'h8000_0400;
    step();
    redirect_pc_i    = 64'h8000_0500;
    step();
    redirect_valid_i = 1'b0;
    #1;
    check("b2b_addr", bus_if.mem_req_addr_o, 64'h8000_0500);
`ifdef TMD_IFU_FLUSH_COUNT_EN
    check("b2b_flush_cnt", flush_count_o, 3);
`else
    check("b2b_flush_cnt", flush_count_o, 0);
`endif
    mem_auto = 1'b1;
    wait_instr("b2b");
    check("b2b_first_pc", bus_if.instr_pc_o, 64'h8000_0500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
